// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: Moore main controller for the multi-cycle ARM-subset datapath.
// Emits unconditional write requests; the condition logic later gates them with CondEx.
module multicycle_control_unit #(
   parameter logic [3:0] PC_REG = 4'd15
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] Op,
   input  logic [5:0] Funct,
   input  logic [3:0] Rd,
   output logic       IRWrite,
   output logic       NextPC,
   output logic       AdrSrc,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUControl,
   output logic [1:0] ImmSrc,
   output logic [1:0] RegSrc,
   output logic       PCS,
   output logic       Register_Wr,
   output logic       Memory_Wr,
   output logic       NoWrite,
   output logic [1:0] FlagW,
   output logic [3:0] State
);
   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECUTER = 4'd6,
      EXECUTEI = 4'd7,
      ALUWB    = 4'd8,
      BRANCH   = 4'd9
   } state_t;
   state_t state, state_nxt;
   logic [3:0] cmd;
   logic exe, wb, is_add, is_sub, is_and, is_orr, is_cmp, known;
   assign cmd    = Funct[4:1];
   assign exe    = (state == EXECUTER) || (state == EXECUTEI);
   assign wb     = (state == MEMWB) || (state == ALUWB);
   assign is_add = cmd == 4'b0100;
   assign is_sub = cmd == 4'b0010;
   assign is_and = cmd == 4'b0000;
   assign is_orr = cmd == 4'b1100;
   assign is_cmp = cmd == 4'b1010;
   assign known  = is_add || is_sub || is_and || is_orr || is_cmp;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) state <= FETCH;
      else state <= state_nxt;
   // Unencoded codes 10-15 fall into the default arm and recover to FETCH.
   always_comb begin
      state_nxt = FETCH;
      case (state)
         FETCH:              state_nxt = DECODE;
         DECODE:             state_nxt = (Op == 2'b01) ? MEMADR :
                                         (Op == 2'b10) ? BRANCH :
                                         (Op == 2'b11) ? FETCH  :
                                         Funct[5]      ? EXECUTEI : EXECUTER;
         MEMADR:             state_nxt = Funct[0] ? MEMREAD : MEMWRITE;
         MEMREAD:            state_nxt = MEMWB;
         EXECUTER, EXECUTEI: state_nxt = ALUWB;
         default:            state_nxt = FETCH;
      endcase
   end
   // Fetch strobes are gated by reset_n because FETCH is also the reset state.
   assign IRWrite     = reset_n && (state == FETCH);
   assign NextPC      = reset_n && (state == FETCH);
   assign AdrSrc      = (state == MEMREAD) || (state == MEMWRITE);
   assign ALUSrcA     = (state == FETCH) || (state == DECODE);
   assign ALUSrcB     = ((state == FETCH) || (state == DECODE)) ? 2'b10 :
                        ((state == MEMADR) || (state == EXECUTEI) || (state == BRANCH)) ? 2'b01 : 2'b00;
   assign ResultSrc   = ((state == FETCH) || (state == DECODE) || (state == BRANCH)) ? 2'b10 :
                        (state == MEMWB) ? 2'b01 : 2'b00;
   assign ALUControl  = !exe ? 2'b00 : (is_sub || is_cmp) ? 2'b01 : is_and ? 2'b10 : is_orr ? 2'b11 : 2'b00;
   assign FlagW       = exe ? {Funct[0] && known, Funct[0] && (is_add || is_sub || is_cmp)} : 2'b00;
   assign NoWrite     = (exe || (state == ALUWB)) && is_cmp;
   assign PCS         = (state == BRANCH) || (wb && (Rd == PC_REG));
   assign Register_Wr = wb;
   assign Memory_Wr   = state == MEMWRITE;
   assign ImmSrc      = Op;
   assign RegSrc      = {Op == 2'b01, Op == 2'b10};
   assign State       = state;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: directed instruction sequences with a scoreboard queue
// of hand-derived per-cycle expectations, checked by an independent monitor.
module tb_multicycle_control_unit;
   logic       clk = 1'b0;
   logic       reset_n;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic [3:0] Rd;
   logic       IRWrite, NextPC, AdrSrc, ALUSrcA, PCS, Register_Wr, Memory_Wr, NoWrite;
   logic [1:0] ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc, FlagW;
   logic [3:0] State;

   multicycle_control_unit dut (
      .clk(clk), .reset_n(reset_n), .Op(Op), .Funct(Funct), .Rd(Rd),
      .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUControl(ALUControl),
      .ImmSrc(ImmSrc), .RegSrc(RegSrc), .PCS(PCS), .Register_Wr(Register_Wr),
      .Memory_Wr(Memory_Wr), .NoWrite(NoWrite), .FlagW(FlagW), .State(State)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      tag;
      logic [3:0] st;
      logic       irw, npc, pcs, rw, mw, nw, adr, srca;
      logic [1:0] fw, srcb, res, aluc, imm, rs;
      logic [4:0] care;  // [0]adr [1]srca [2]srcb [3]res [4]aluc
   } exp_t;

   exp_t q[$];
   event smp;
   int n_cmp = 0;
   int n_bad = 0;
   logic [1:0] cur_imm, cur_rs;
   logic [23:0] got, want, m;

   // Spec output table per state; instruction-specific fields are overridden by callers.
   function automatic exp_t mk(input string tag, input logic [3:0] st);
      exp_t e;
      e.tag = tag; e.st = st;
      e.irw = 0; e.npc = 0; e.pcs = 0; e.rw = 0; e.mw = 0; e.nw = 0; e.adr = 0; e.srca = 0;
      e.fw = 0; e.srcb = 0; e.res = 0; e.aluc = 0; e.imm = cur_imm; e.rs = cur_rs; e.care = 0;
      case (st)
         4'd0: begin e.irw = 1; e.npc = 1; e.srca = 1; e.srcb = 2; e.res = 2; e.care = 5'b11111; end
         4'd1: begin e.srca = 1; e.srcb = 2; e.res = 2; e.care = 5'b11110; end
         4'd2: begin e.srcb = 1; e.care = 5'b10110; end
         4'd3: begin e.adr = 1; e.care = 5'b01001; end
         4'd4: begin e.res = 1; e.rw = 1; e.care = 5'b01000; end
         4'd5: begin e.adr = 1; e.mw = 1; e.care = 5'b00001; end
         4'd6: e.care = 5'b00110;
         4'd7: begin e.srcb = 1; e.care = 5'b00110; end
         4'd8: begin e.rw = 1; e.care = 5'b01000; end
         4'd9: begin e.srcb = 1; e.res = 2; e.pcs = 1; e.care = 5'b11110; end
         default: e.care = 0;
      endcase
      return e;
   endfunction

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk or smp);
         if (q.size() != 0) begin
            e = q.pop_front();
            got  = {State, IRWrite, NextPC, PCS, Register_Wr, Memory_Wr, NoWrite, FlagW,
                    AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc};
            want = {e.st, e.irw, e.npc, e.pcs, e.rw, e.mw, e.nw, e.fw,
                    e.adr, e.srca, e.srcb, e.res, e.aluc, e.imm, e.rs};
            m    = {12'hfff, e.care[0], e.care[1], {2{e.care[2]}}, {2{e.care[3]}}, {2{e.care[4]}}, 4'hf};
            n_cmp++;
            if (((got ^ want) & m) != 0) begin
               n_bad++;
               $display("FAIL %s: got %h want %h (mask %h)", e.tag, got, want, m);
            end
         end
      end
   end

   task automatic cyc(input exp_t e);
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd,
                         input logic [1:0] imm, input logic [1:0] rs);
      Op = op; Funct = f; Rd = rd; cur_imm = imm; cur_rs = rs;
   endtask

   task automatic dp(input string t, input logic [5:0] f, input logic [3:0] rd, input logic [3:0] ex,
                     input logic [1:0] al, input logic [1:0] fw, input logic nw, input logic pcs);
      exp_t e;
      set_in(2'b00, f, rd, 2'b00, 2'b00);
      cyc(mk({t, "_f"}, 4'd0));
      cyc(mk({t, "_d"}, 4'd1));
      e = mk({t, "_ex"}, ex); e.aluc = al; e.care[4] = 1; e.fw = fw; e.nw = nw;
      cyc(e);
      e = mk({t, "_wb"}, 4'd8); e.nw = nw; e.pcs = pcs;
      cyc(e);
   endtask

   initial begin : stim
      exp_t e;
      reset_n = 0;
      set_in(2'b00, 6'b001001, 4'd1, 2'b00, 2'b00);
      #1;
      e = mk("rst_init", 4'd0); e.irw = 0; e.npc = 0;
      q.push_back(e); ->smp;
      @(posedge clk); @(posedge clk); #1;
      reset_n = 1;
      dp("adds",   6'b001001, 4'd1,  4'd6, 2'b00, 2'b11, 1'b0, 1'b0);
      dp("cmpi",   6'b110101, 4'd0,  4'd7, 2'b01, 2'b11, 1'b1, 1'b0);
      dp("ands",   6'b000001, 4'd4,  4'd6, 2'b10, 2'b10, 1'b0, 1'b0);
      dp("orr",    6'b011000, 4'd5,  4'd6, 2'b11, 2'b00, 1'b0, 1'b0);
      dp("movs",   6'b011011, 4'd6,  4'd6, 2'b00, 2'b00, 1'b0, 1'b0);
      dp("subspc", 6'b000101, 4'd15, 4'd6, 2'b01, 2'b11, 1'b0, 1'b1);
      set_in(2'b01, 6'b011001, 4'd15, 2'b01, 2'b10);
      cyc(mk("ldrpc_f", 4'd0)); cyc(mk("ldrpc_d", 4'd1)); cyc(mk("ldrpc_ma", 4'd2));
      cyc(mk("ldrpc_mr", 4'd3));
      e = mk("ldrpc_wb", 4'd4); e.pcs = 1; cyc(e);
      set_in(2'b01, 6'b011000, 4'd3, 2'b01, 2'b10);
      cyc(mk("str_f", 4'd0)); cyc(mk("str_d", 4'd1)); cyc(mk("str_ma", 4'd2)); cyc(mk("str_mw", 4'd5));
      set_in(2'b10, 6'b000000, 4'd0, 2'b10, 2'b01);
      cyc(mk("b_f", 4'd0)); cyc(mk("b_d", 4'd1)); cyc(mk("b_br", 4'd9));
      set_in(2'b11, 6'b000000, 4'd0, 2'b11, 2'b00);
      cyc(mk("und_f", 4'd0)); cyc(mk("und_d", 4'd1));
      // Asynchronous reset in the middle of a load's MEMREAD cycle.
      set_in(2'b01, 6'b011001, 4'd2, 2'b01, 2'b10);
      cyc(mk("ldr_f", 4'd0)); cyc(mk("ldr_d", 4'd1)); cyc(mk("ldr_ma", 4'd2));
      q.push_back(mk("ldr_mr", 4'd3));
      @(negedge clk); #2;
      reset_n = 0;
      #1;
      e = mk("rst_mid", 4'd0); e.irw = 0; e.npc = 0;
      q.push_back(e); ->smp;
      @(posedge clk); #1;
      e = mk("rst_hold", 4'd0); e.irw = 0; e.npc = 0;
      q.push_back(e);
      @(posedge clk); #1;
      reset_n = 1;
      cyc(mk("rel_f", 4'd0)); cyc(mk("rel_d", 4'd1)); cyc(mk("rel_ma", 4'd2));
      cyc(mk("rel_mr", 4'd3)); cyc(mk("rel_wb", 4'd4));
      cyc(mk("end_f", 4'd0));
      for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending entries, want 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish, want finish before 100000");
      $fatal(1);
   end
endmodule
